// File: rtl/tsr_pkg.sv
// -----------------------------------------------------------------------------
// tsr_pkg
// Shared definitions for the timestamp readout arbiter: the readout FSM state
// encoding, the frame header magic byte, channel index constants and the
// header word builder.
// -----------------------------------------------------------------------------
package tsr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LO,
        ST_HI,
        ST_PH,
        ST_RELEASE,
        ST_WAIT_CLR
    } state_t;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    // Channel index as carried in the header word and in the grant register.
    localparam logic CH1 = 1'b0;
    localparam logic CH2 = 1'b1;

    // Header layout: magic, frame sequence number, zero padding, channel bit.
    function automatic logic [31:0] make_header(input logic [7:0] seq, input logic ch);
        return {HDR_MAGIC, seq, 15'h0000, ch};
    endfunction

endpackage

// File: rtl/tsr_sync.sv
// -----------------------------------------------------------------------------
// tsr_sync
// Single-bit multi-flop synchroniser for the asynchronous latch-ready flags.
//
// Ports:
//   clk  input   system clock
//   rst  input   asynchronous active-high reset (clears every stage)
//   d    input   asynchronous level to synchronise
//   q    output  synchronised level, pSYNC_STAGES clocks behind d
// -----------------------------------------------------------------------------
module tsr_sync #(
    parameter int pSYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [pSYNC_STAGES-1:0] stages;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[pSYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[pSYNC_STAGES-1];

endmodule

// File: rtl/timestamp_readout_arbiter.sv
// -----------------------------------------------------------------------------
// timestamp_readout_arbiter
// Round-robin readout controller for the two-channel timestamp latch counter.
// When a channel's ready flag is seen, its latched value is sent as a framed
// word stream (header, Lo, Hi[, Phase]), the channel's latch is released with a
// one-cycle pulse, and the controller waits for the ready flag to clear (or a
// timeout, which sets a sticky error bit) before returning to IDLE.
//
// Build option: define TSR_PHASE_EN to include the Phase word (4-word frames);
// without it frames are 3 words and the Phase inputs are ignored.
//
// Ports:
//   globalClock               input   system clock
//   iReset                    input   asynchronous active-high reset
//   iRdy1 / iRdy2             input   asynchronous latch-ready flags
//   i1Lo/i1Hi/i1Phase         input   channel 1 latched value
//   i2Lo/i2Hi/i2Phase         input   channel 2 latched value
//   oWord                     output  stream data word
//   oValid                    output  oWord valid (HDR..last data state)
//   iReady                    input   downstream accept
//   oResetLatch1/2            output  one-cycle latch release pulse
//   oBusy                     output  high whenever not IDLE
//   oErr                      output  sticky per-channel clear-timeout flags
// -----------------------------------------------------------------------------
module timestamp_readout_arbiter #(
    parameter int pSYNC_STAGES = 2,
    parameter int pCLR_TIMEOUT = 255
) (
    input  logic        globalClock,
    input  logic        iReset,
    input  logic        iRdy1,
    input  logic        iRdy2,
    input  logic [31:0] i1Lo,
    input  logic [31:0] i1Hi,
    input  logic [31:0] i1Phase,
    input  logic [31:0] i2Lo,
    input  logic [31:0] i2Hi,
    input  logic [31:0] i2Phase,
    output logic [31:0] oWord,
    output logic        oValid,
    input  logic        iReady,
    output logic        oResetLatch1,
    output logic        oResetLatch2,
    output logic        oBusy,
    output logic [1:0]  oErr
);

    import tsr_pkg::*;

    localparam int CNT_W = $clog2(pCLR_TIMEOUT + 1);

    logic             rdy_s1, rdy_s2;
    state_t           state, state_next;
    logic             grant_ch, grant_ch_next;
    logic             last_grant, last_grant_next;
    logic [7:0]       seq, seq_next;
    logic [31:0]      word, word_next;
    logic [CNT_W-1:0] clr_cnt, clr_cnt_next, clr_cnt_inc;
    logic [1:0]       err, err_next;
    logic             pick;
    logic             accept;
    logic             rdy_granted;
    logic [31:0]      sel_lo, sel_hi;

    tsr_sync #(.pSYNC_STAGES(pSYNC_STAGES)) u_sync1 (
        .clk (globalClock),
        .rst (iReset),
        .d   (iRdy1),
        .q   (rdy_s1)
    );

    tsr_sync #(.pSYNC_STAGES(pSYNC_STAGES)) u_sync2 (
        .clk (globalClock),
        .rst (iReset),
        .d   (iRdy2),
        .q   (rdy_s2)
    );

    assign sel_lo      = (grant_ch == CH2) ? i2Lo : i1Lo;
    assign sel_hi      = (grant_ch == CH2) ? i2Hi : i1Hi;
    assign rdy_granted = (grant_ch == CH2) ? rdy_s2 : rdy_s1;
    assign accept      = oValid && iReady;
    assign clr_cnt_inc = clr_cnt + CNT_W'(1);

    // On a tie the channel not served last wins; otherwise whichever is ready.
    assign pick = (rdy_s1 && rdy_s2) ? ~last_grant : rdy_s2;

`ifdef TSR_PHASE_EN
    logic [31:0] sel_ph;
    assign sel_ph = (grant_ch == CH2) ? i2Phase : i1Phase;
`else
    logic unused_phase;
    assign unused_phase = ^{i1Phase, i2Phase};
`endif

    always_ff @(posedge globalClock or posedge iReset) begin
        if (iReset) begin
            state      <= ST_IDLE;
            grant_ch   <= CH1;
            last_grant <= CH2;
            seq        <= 8'h00;
            word       <= 32'h0;
            clr_cnt    <= '0;
            err        <= 2'b00;
        end else begin
            state      <= state_next;
            grant_ch   <= grant_ch_next;
            last_grant <= last_grant_next;
            seq        <= seq_next;
            word       <= word_next;
            clr_cnt    <= clr_cnt_next;
            err        <= err_next;
        end
    end

    // Each data word is loaded into the output register on the edge that
    // enters its state, then held there until the downstream accepts it.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_next      = state;
        grant_ch_next   = grant_ch;
        last_grant_next = last_grant;
        seq_next        = seq;
        word_next       = word;
        clr_cnt_next    = clr_cnt;
        err_next        = err;

        case (state)
            ST_IDLE: begin
                if (rdy_s1 || rdy_s2) begin
                    grant_ch_next = pick;
                    word_next     = make_header(seq, pick);
                    state_next    = ST_HDR;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    word_next  = sel_lo;
                    state_next = ST_LO;
                end
            end
            ST_LO: begin
                if (accept) begin
                    word_next  = sel_hi;
                    state_next = ST_HI;
                end
            end
            ST_HI: begin
                if (accept) begin
`ifdef TSR_PHASE_EN
                    word_next  = sel_ph;
                    state_next = ST_PH;
`else
                    word_next  = 32'h0;
                    seq_next   = seq + 8'd1;
                    state_next = ST_RELEASE;
`endif
                end
            end
`ifdef TSR_PHASE_EN
            ST_PH: begin
                if (accept) begin
                    word_next  = 32'h0;
                    seq_next   = seq + 8'd1;
                    state_next = ST_RELEASE;
                end
            end
`endif
            ST_RELEASE: begin
                last_grant_next = grant_ch;
                clr_cnt_next    = '0;
                state_next      = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                if (!rdy_granted) begin
                    state_next = ST_IDLE;
                end else if (clr_cnt_inc == CNT_W'(pCLR_TIMEOUT)) begin
                    // Stuck channel: flag it but keep it eligible for service.
                    err_next[grant_ch] = 1'b1;
                    state_next         = ST_IDLE;
                end else begin
                    clr_cnt_next = clr_cnt_inc;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign oWord        = word;
    assign oValid       = (state == ST_HDR) || (state == ST_LO) || (state == ST_HI)
                       || (state == ST_PH);
    assign oBusy        = (state != ST_IDLE);
    assign oResetLatch1 = (state == ST_RELEASE) && (grant_ch == CH1);
    assign oResetLatch2 = (state == ST_RELEASE) && (grant_ch == CH2);
    assign oErr         = err;

endmodule

// File: tb/tb_timestamp_readout_arbiter.sv
// -----------------------------------------------------------------------------
// tb_timestamp_readout_arbiter
// Self-checking bench for timestamp_readout_arbiter. Expected frames are built
// from the frame format, a bench-side sequence counter and the round-robin
// rule (tie goes to the channel not served last).
// -----------------------------------------------------------------------------
module tb_timestamp_readout_arbiter;

    localparam int SYNC = 2;
    localparam int TMO  = 8;
`ifdef TSR_PHASE_EN
    localparam int N_WORDS = 4;
`else
    localparam int N_WORDS = 3;
`endif

    logic        clk = 1'b0;
    logic        iReset = 1'b1;
    logic        iRdy1 = 1'b0;
    logic        iRdy2 = 1'b0;
    logic        iReady = 1'b0;
    logic [31:0] lo_v [2];
    logic [31:0] hi_v [2];
    logic [31:0] ph_v [2];
    logic [31:0] oWord;
    logic        oValid;
    logic        oResetLatch1;
    logic        oResetLatch2;
    logic        oBusy;
    logic [1:0]  oErr;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] seq_m = 8'h00;
    logic       last_m = 1'b1;

    always #5 clk = ~clk;

    timestamp_readout_arbiter #(
        .pSYNC_STAGES (SYNC),
        .pCLR_TIMEOUT (TMO)
    ) dut (
        .globalClock  (clk),
        .iReset       (iReset),
        .iRdy1        (iRdy1),
        .iRdy2        (iRdy2),
        .i1Lo         (lo_v[0]),
        .i1Hi         (hi_v[0]),
        .i1Phase      (ph_v[0]),
        .i2Lo         (lo_v[1]),
        .i2Hi         (hi_v[1]),
        .i2Phase      (ph_v[1]),
        .oWord        (oWord),
        .oValid       (oValid),
        .iReady       (iReady),
        .oResetLatch1 (oResetLatch1),
        .oResetLatch2 (oResetLatch2),
        .oBusy        (oBusy),
        .oErr         (oErr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_rdy(input logic ch, input logic v);
        if (ch) iRdy2 = v;
        else    iRdy1 = v;
    endtask

    task automatic new_data(input logic ch);
        lo_v[ch] = $urandom;
        hi_v[ch] = $urandom;
        ph_v[ch] = $urandom;
    endtask

    task automatic apply_reset();
        iReset = 1'b1;
        iRdy1  = 1'b0;
        iRdy2  = 1'b0;
        iReady = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_word",  oWord, 32'h0);
        check("rst_valid", 32'(oValid), 32'h0);
        check("rst_rl1",   32'(oResetLatch1), 32'h0);
        check("rst_rl2",   32'(oResetLatch2), 32'h0);
        check("rst_busy",  32'(oBusy), 32'h0);
        check("rst_err",   32'(oErr), 32'h0);
        iReset = 1'b0;
        seq_m  = 8'h00;
        last_m = 1'b1;
    endtask

    // Collects one frame from channel ch and checks every word, the hold
    // behaviour under back-pressure, and the release pulse that follows.
    // Returns at the negedge of the first cycle after the release pulse.
    task automatic do_frame(input logic ch, input bit rand_ready, output int first_at);
        logic [31:0] exp_w [4];
        int idx;
        int guard;
        exp_w[0] = {8'hA5, seq_m, 15'h0000, ch};
        exp_w[1] = lo_v[ch];
        exp_w[2] = hi_v[ch];
        exp_w[3] = ph_v[ch];
        idx      = 0;
        guard    = 0;
        first_at = -1;
        while (idx < N_WORDS && guard < 400) begin
            @(negedge clk);
            guard++;
            if (idx > 0) check("valid_in_frame", 32'(oValid), 32'h1);
            iReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (oValid) begin
                if (first_at < 0) first_at = guard;
                check(iReady ? "word" : "held_word", oWord, exp_w[idx]);
                if (iReady) idx++;
            end
        end
        if (idx < N_WORDS) check("frame_timeout", 32'(idx), 32'(N_WORDS));
        @(negedge clk);
        iReady = 1'b0;
        check("release_rl1",  32'(oResetLatch1), 32'(ch == 1'b0));
        check("release_rl2",  32'(oResetLatch2), 32'(ch == 1'b1));
        check("release_valid", 32'(oValid), 32'h0);
        seq_m  = seq_m + 8'd1;
        last_m = ch;
        @(negedge clk);
        check("pulse_width_rl1", 32'(oResetLatch1), 32'h0);
        check("pulse_width_rl2", 32'(oResetLatch2), 32'h0);
    endtask

    task automatic release_wait(input logic ch);
        int guard;
        set_rdy(ch, 1'b0);
        guard = 0;
        while (oBusy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("idle_return", 32'(oBusy), 32'h0);
    endtask

    initial begin
        int first_at;
        int guard;
        int kind;
        logic first;

        for (int c = 0; c < 2; c++) begin
            lo_v[c] = 32'h0;
            hi_v[c] = 32'h0;
            ph_v[c] = 32'h0;
        end

        // Reset state.
        apply_reset();

        // Single channel 1 frame with fixed data and iReady held high; also
        // checks the ready-to-grant latency.
        lo_v[0] = 32'h1111_0001;
        hi_v[0] = 32'h0000_0000;
        ph_v[0] = 32'h0000_0ABC;
        iReady  = 1'b1;
        iRdy1   = 1'b1;
        for (int k = 0; k < SYNC; k++) begin
            @(negedge clk);
            check("grant_latency_idle", 32'(oValid), 32'h0);
        end
        do_frame(1'b0, 1'b0, first_at);
        check("grant_latency", 32'(first_at), 32'h1);
        release_wait(1'b0);

        // Simultaneous ready after reset: channel 1 first, then channel 2.
        apply_reset();
        new_data(1'b0);
        new_data(1'b1);
        iRdy1 = 1'b1;
        iRdy2 = 1'b1;
        do_frame(1'b0, 1'b0, first_at);
        release_wait(1'b0);
        check("tie_second_seq", 32'(seq_m), 32'h1);
        do_frame(1'b1, 1'b0, first_at);
        release_wait(1'b1);

        // Stuck channel 2: ready held after release, timeout sets oErr[1].
        new_data(1'b1);
        iRdy2 = 1'b1;
        do_frame(1'b1, 1'b1, first_at);
        check("tmo_err_early", 32'(oErr), 32'h0);
        check("tmo_busy_early", 32'(oBusy), 32'h1);
        for (int k = 2; k <= TMO; k++) begin
            @(negedge clk);
            check("tmo_busy", 32'(oBusy), 32'h1);
            check("tmo_err_pending", 32'(oErr), 32'h0);
        end
        @(negedge clk);
        check("tmo_err_set", 32'(oErr), 32'h2);
        check("tmo_idle", 32'(oBusy), 32'h0);
        // The flagged channel is still eligible and is served again at once.
        iRdy2 = 1'b0;
        do_frame(1'b1, 1'b0, first_at);
        release_wait(1'b1);
        check("tmo_err_sticky", 32'(oErr), 32'h2);

        // Reset while the Lo word is on the bus.
        apply_reset();
        check("err_cleared", 32'(oErr), 32'h0);
        new_data(1'b0);
        iReady = 1'b1;
        iRdy1  = 1'b1;
        guard  = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!oValid && guard < 20);
        check("abort_hdr", oWord, 32'hA500_0000);
        @(negedge clk);
        check("abort_lo", oWord, lo_v[0]);
        iReset = 1'b1;
        #1;
        check("abort_valid", 32'(oValid), 32'h0);
        check("abort_busy", 32'(oBusy), 32'h0);
        check("abort_word", oWord, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_rl1", 32'(oResetLatch1), 32'h0);
            check("abort_no_rl2", 32'(oResetLatch2), 32'h0);
        end
        iReset = 1'b0;
        seq_m  = 8'h00;
        last_m = 1'b1;
        do_frame(1'b0, 1'b0, first_at);
        release_wait(1'b0);

        // Randomised frames with random back-pressure; enough of them for the
        // header sequence number to wrap FF -> 00.
        for (int f = 0; f < 270; f++) begin
            kind = $urandom_range(0, 2);
            if (kind == 2) begin
                new_data(1'b0);
                new_data(1'b1);
                first  = ~last_m;
                iRdy1  = 1'b1;
                iRdy2  = 1'b1;
                do_frame(first, 1'b1, first_at);
                release_wait(first);
                do_frame(~first, 1'b1, first_at);
                release_wait(~first);
            end else begin
                first = (kind == 1);
                new_data(first);
                set_rdy(first, 1'b1);
                do_frame(first, 1'b1, first_at);
                release_wait(first);
            end
        end
        check("err_clean_after_random", 32'(oErr), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
